temp_sampler: RTL
=================

Name: temp_sampler

Overview:
- Front-end stage feeding the thermostat controller.
- Accumulates raw 8-bit samples from two sensors, t (ambient) and g (set-point sensor), over blocks of 2^LOG2_N samples.
- Publishes the block averages as a registered 8-bit `gt` and a hysteretic `t_g_gt` flag; these are the controller's `gt`/`t_g_gt` inputs.
- Decimating: outputs update once per completed block and hold between updates.

Parameters:
- LOG2_N, 3, log2 of samples per block (N = 8); legal range 0..6.
- HYST, 2, comparison hysteresis in LSBs; legal range 0..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- t_raw  input  8  raw t sample, unsigned; qualified by sample_valid.
- g_raw  input  8  raw g sample, unsigned; qualified by sample_valid.
- sample_valid  input  1  one-cycle-or-longer qualifier; each high cycle is one sample pair.
- gt  output  8  registered average of g over the last completed block.
- t_g_gt  output  1  registered hysteretic flag "t average exceeds g average".
- avg_valid  output  1  one-cycle pulse in the cycle `gt`/`t_g_gt` take new values.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values (rst high at a clock edge): gt = 0, t_g_gt = 0, avg_valid = 0, both accumulators = 0, sample counter = 0. Samples presented while rst is high are ignored.
- Accumulators: acc_t, acc_g, each 8+LOG2_N bits unsigned; they cannot overflow.
- Counter: cnt, LOG2_N bits (1 bit minimum, forced to 0 when LOG2_N = 0).
- Two states: ACCUM (default) and PUBLISH (single cycle, implemented as a registered pulse).
- Cycle with sample_valid = 1 and cnt != N-1:
  - acc_t += t_raw, acc_g += g_raw, cnt += 1.
  - avg_valid = 0.
- Cycle with sample_valid = 1 and cnt == N-1 (block-completing sample):
  - sum_t = acc_t + t_raw, sum_g = acc_g + g_raw.
  - avg_t = sum_t >> LOG2_N, avg_g = sum_g >> LOG2_N. Truncate, no rounding.
  - Next edge: gt <= avg_g, t_g_gt updated per the hysteresis rule, avg_valid <= 1, accumulators <= 0, cnt <= 0.
  - Latency: last sample edge to new outputs = 1 clock.
- sample_valid = 0: accumulators, cnt and outputs hold; avg_valid = 0.
- Back-to-back blocks: sample_valid held high continuously gives an avg_valid pulse every N cycles. The sample arriving in the publish cycle is accumulated into the next block; no sample is dropped.
- Hysteresis rule, evaluated only at publish, in 9-bit unsigned arithmetic:
  - avg_t > avg_g + HYST: t_g_gt <= 1.
  - avg_t + HYST < avg_g: t_g_gt <= 0.
  - Otherwise t_g_gt holds its previous value.
  - HYST = 0: equal averages hold the flag.
- avg_avg_t is internal only; not exported.
- Reset mid-block: partial sums and cnt discarded; outputs return to reset values. The first avg_valid after reset requires N fresh samples.
- LOG2_N = 0: every valid sample publishes directly (N = 1); averages equal the raw inputs.
- Boundary values: all-255 inputs give avg 255 exactly (no overflow); all-0 inputs give avg 0.

Decomposition:
- Shared package (thermo_pkg): sensor sample width constant (8), controller threshold constants (GE90/IDLE_HIGH/IDLE_LOW/LE70 values), default LOG2_N and HYST.
- One natural sub-module: block_avg, a single-channel accumulator with shifted average output, parameterised by LOG2_N.
  - Instantiated twice (t and g).
  - Shares the count/publish strobe generated in temp_sampler.
- Comparator/hysteresis logic and output registers stay in temp_sampler.

Test Plan:
1. Reset then 8 valid pairs t = 100, g = 80 (consecutive cycles) -> avg_valid single pulse 1 cycle after the 8th sample; gt = 80, t_g_gt = 1.
2. Block g = 10,20,...,80, t = 0 -> sum_g = 360, gt = 45 (truncated); t_g_gt = 0. Next block t = 46, g = 45 with HYST = 2 -> t_g_gt holds 0. Next block t = 48, g = 45 -> t_g_gt = 1.
3. sample_valid toggling every other cycle for 16 samples -> exactly 2 avg_valid pulses, each 1 cycle after the 8th and 16th valid samples; outputs stable between pulses.
4. All samples t = g = 255 for one block -> gt = 255, no wrap. Then t = 0, g = 255 -> t_g_gt = 0.
5. Assert rst after 5 samples of a block (with a prior published gt = 80) -> at that edge gt = 0, t_g_gt = 0; the next avg_valid occurs only after 8 further samples, with averages computed from post-reset samples only.
6. sample_valid held high for 24 cycles, t = 90, g = 70 -> avg_valid at cycles 9, 17, 25 relative to first sample; no sample lost (verify per-block sums against a model).

Source files
------------

// File: rtl/thermo_pkg.sv
// ============================================================================
// thermo_pkg : shared constants, state type and hysteresis helper
// Rev 1.0
// ============================================================================
`default_nettype none

package thermo_pkg;

  localparam int SAMPLE_W       = 8;
  localparam int DEFAULT_LOG2_N = 3;
  localparam int DEFAULT_HYST   = 2;

  // Thresholds consumed by the downstream thermostat controller
  localparam logic [SAMPLE_W-1:0] GE90_TH      = 8'd90;
  localparam logic [SAMPLE_W-1:0] IDLE_HIGH_TH = 8'd78;
  localparam logic [SAMPLE_W-1:0] IDLE_LOW_TH  = 8'd72;
  localparam logic [SAMPLE_W-1:0] LE70_TH      = 8'd70;

  typedef enum logic [0:0] {
    ST_ACCUM   = 1'b0,
    ST_PUBLISH = 1'b1
  } smp_state_e;

  // 9-bit compare so that avg + hyst never wraps
  function automatic logic hyst_flag(input logic [SAMPLE_W-1:0] avg_t,
                                     input logic [SAMPLE_W-1:0] avg_g,
                                     input logic [3:0]          hyst,
                                     input logic                prev);
    logic [SAMPLE_W:0] t9;
    logic [SAMPLE_W:0] g9;
    logic [SAMPLE_W:0] h9;
    t9 = {1'b0, avg_t};
    g9 = {1'b0, avg_g};
    h9 = {5'b0, hyst};
    if (t9 > g9 + h9) begin
      return 1'b1;
    end else if (t9 + h9 < g9) begin
      return 1'b0;
    end
    return prev;
  endfunction

endpackage

`default_nettype wire

// File: rtl/block_avg.sv
// ============================================================================
// block_avg : single-channel block accumulator with truncated average output
// Rev 1.0
// ============================================================================
`default_nettype none

module block_avg
  import thermo_pkg::*;
#(
  parameter int LOG2_N = DEFAULT_LOG2_N
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] sample_i,
  input  logic                add_i,
  input  logic                last_i,
  output logic [SAMPLE_W-1:0] avg_o
);

  localparam int ACC_W = SAMPLE_W + LOG2_N;

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W-1:0] sum;

  // N samples of at most 255 always fit in ACC_W bits
  assign sum   = acc_q + ACC_W'(sample_i);
  assign avg_o = sum[ACC_W-1:LOG2_N];

  always_comb begin
    acc_d = acc_q;
    if (add_i) begin
      acc_d = last_i ? '0 : sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/temp_sampler.sv
// ============================================================================
// temp_sampler : decimating t/g block averager with hysteretic t>g flag
// Rev 1.0
// ============================================================================
`default_nettype none

module temp_sampler
  import thermo_pkg::*;
#(
  parameter int LOG2_N = DEFAULT_LOG2_N,
  parameter int HYST   = DEFAULT_HYST
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] t_raw,
  input  logic [SAMPLE_W-1:0] g_raw,
  input  logic                sample_valid,
  output logic [SAMPLE_W-1:0] gt,
  output logic                t_g_gt,
  output logic                avg_valid
);

  localparam int              CNT_W    = (LOG2_N > 0) ? LOG2_N : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_N) - 1);

  logic [CNT_W-1:0]    cnt_q;
  logic                last_sample;
  logic [SAMPLE_W-1:0] avg_t;
  logic [SAMPLE_W-1:0] avg_g;

  smp_state_e          state_q;
  smp_state_e          state_d;
  logic [SAMPLE_W-1:0] gt_q;
  logic [SAMPLE_W-1:0] gt_d;
  logic                flag_q;
  logic                flag_d;

  assign last_sample = sample_valid && (cnt_q == CNT_LAST);

  // Counter width equals LOG2_N, so it wraps to 0 on the block-completing sample
  generate
    if (LOG2_N == 0) begin : g_cnt_none
      assign cnt_q = '0;
    end else begin : g_cnt_reg
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_q <= '0;
        end else if (sample_valid) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  endgenerate

  block_avg #(.LOG2_N(LOG2_N)) u_avg_t (
    .clk      (clk),
    .rst      (rst),
    .sample_i (t_raw),
    .add_i    (sample_valid),
    .last_i   (last_sample),
    .avg_o    (avg_t)
  );

  block_avg #(.LOG2_N(LOG2_N)) u_avg_g (
    .clk      (clk),
    .rst      (rst),
    .sample_i (g_raw),
    .add_i    (sample_valid),
    .last_i   (last_sample),
    .avg_o    (avg_g)
  );

  always_comb begin
    state_d = ST_ACCUM;
    gt_d    = gt_q;
    flag_d  = flag_q;
    if (last_sample) begin
      state_d = ST_PUBLISH;
      gt_d    = avg_g;
      flag_d  = hyst_flag(avg_t, avg_g, 4'(HYST), flag_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACCUM;
      gt_q    <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gt_q    <= gt_d;
      flag_q  <= flag_d;
    end
  end

  assign gt        = gt_q;
  assign t_g_gt    = flag_q;
  assign avg_valid = (state_q == ST_PUBLISH);

endmodule

`default_nettype wire
